adc_frame_sync_gen: RTL and testbench

//  Source end of the en_sync/cnt_sync 4-lane framing interface consumed by the pipeline delay stages.

---
 rtl/adc_frame_sync_gen_if.sv | 32 +++
 rtl/adc_frame_sync_gen.sv | 182 ++++++++++++++++++
 tb/tb_adc_frame_sync_gen.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/adc_frame_sync_gen_if.sv
// ----------------------------------------------------------------------------
// adc_frame_sync_gen_if
//   Framed 4-lane output bus of the ADC frame sync generator (en_sync/cnt_sync
//   framing consumed by the pipeline delay stages).
//   Signals:
//     en_sync_out   lane data / count qualifier
//     cnt_sync_out  beat index within the frame (BITWIDTH+2 bits)
//     dout0..dout3  lane data, lane0 = oldest sample
//     frame_start   beat 0 of a frame
//     sub_start     first beat of a sub-frame
//   Modports: master = generator (drives), slave = consumer (receives).
// ----------------------------------------------------------------------------
interface adc_frame_sync_gen_if #(
  parameter int BITWIDTH = 7
);
  logic                  en_sync_out;
  logic [BITWIDTH+1:0]   cnt_sync_out;
  logic [15:0]           dout0;
  logic [15:0]           dout1;
  logic [15:0]           dout2;
  logic [15:0]           dout3;
  logic                  frame_start;
  logic                  sub_start;

  modport master (
    output en_sync_out, cnt_sync_out, dout0, dout1, dout2, dout3, frame_start, sub_start
  );

  modport slave (
    input en_sync_out, cnt_sync_out, dout0, dout1, dout2, dout3, frame_start, sub_start
  );
endinterface

// File: rtl/adc_frame_sync_gen.sv
// ----------------------------------------------------------------------------
// adc_frame_sync_gen
//   Frames raw 4-lane ADC beats (4 x 16b samples per clk) into frames of
//   FFT_POINT samples (FRAME_CYC = FFT_POINT/4 beats) and emits them with an
//   en_sync qualifier, an in-frame beat count and frame/sub-frame markers.
//   A frame, once started, is always emitted complete unless rst intervenes.
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     start, stop       framing control pulses
//     adc_valid, din0-3 ADC beat input (din0 = oldest sample)
//     busy              registered, high in ARM/RUN/DRAIN
//     fr                framed output bus (master side); its BITWIDTH must
//                       match this module's BITWIDTH
//   Latency din/adc_valid -> dout/en_sync_out is one clock.
// ----------------------------------------------------------------------------
module adc_frame_sync_gen #(
  parameter int BITWIDTH      = 7,
  parameter int FFT_POINT     = 512,
  parameter int SUB_FFT_POINT = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        adc_valid,
  input  logic [15:0] din0,
  input  logic [15:0] din1,
  input  logic [15:0] din2,
  input  logic [15:0] din3,
  output logic        busy,
  adc_frame_sync_gen_if.master fr
);

  localparam int CW        = BITWIDTH + 2;
  localparam int FRAME_CYC = FFT_POINT / 4;
  localparam int SUB_CYC   = SUB_FFT_POINT / 4;

  localparam logic [CW-1:0] LAST_BEAT = CW'(FRAME_CYC - 1);
  localparam logic [CW-1:0] SUB_LEN   = CW'(SUB_CYC);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       beat_q, beat_d;        // index of the next beat to emit
  logic                stop_pend_q, stop_pend_d;
  logic                en_q, en_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [3:0][15:0]    dout_q, dout_d;
  logic                fs_q, fs_d;
  logic                ss_q, ss_d;
  logic                busy_q, busy_d;
  logic                emit_s;
  logic                last_s;

  assign last_s = (beat_q == LAST_BEAT);

  // Next-state, beat counter and output-register computation
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    stop_pend_d = stop_pend_q;
    en_d        = 1'b0;
    cnt_d       = cnt_q;
    dout_d      = dout_q;
    fs_d        = 1'b0;
    ss_d        = 1'b0;
    busy_d      = 1'b0;
    emit_s      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = ARM;
        end else begin
          state_d = IDLE;
        end
      end
      ARM: begin
        // stop wins over a coincident first beat: nothing is emitted
        if (stop) begin
          state_d = IDLE;
        end else if (adc_valid) begin
          emit_s  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = ARM;
        end
      end
      RUN: begin
        emit_s = adc_valid;
        if (stop || stop_pend_q) begin
          if (adc_valid && last_s) begin
            state_d = IDLE;
          end else if (adc_valid || (beat_q != '0)) begin
            // a frame is in progress (or starts now): finish it
            state_d = DRAIN;
          end else begin
            // sitting on a frame boundary: nothing left to finish
            state_d = IDLE;
          end
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        emit_s = adc_valid;
        if (adc_valid && last_s) begin
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (emit_s) begin
      en_d   = 1'b1;
      cnt_d  = beat_q;
      dout_d = {din3, din2, din1, din0};
      fs_d   = (beat_q == '0);
      ss_d   = ((beat_q % SUB_LEN) == '0);
      beat_d = last_s ? '0 : (beat_q + 1'b1);
    end else if (state_q == IDLE) begin
      beat_d = '0;
    end else begin
      beat_d = beat_q;
    end

    if (state_d == IDLE) begin
      stop_pend_d = 1'b0;
    end else if (((state_q == RUN) || (state_q == DRAIN)) && stop) begin
      stop_pend_d = 1'b1;
    end else begin
      stop_pend_d = stop_pend_q;
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      stop_pend_q <= 1'b0;
      en_q        <= 1'b0;
      cnt_q       <= '0;
      dout_q      <= '0;
      fs_q        <= 1'b0;
      ss_q        <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      stop_pend_q <= stop_pend_d;
      en_q        <= en_d;
      cnt_q       <= cnt_d;
      dout_q      <= dout_d;
      fs_q        <= fs_d;
      ss_q        <= ss_d;
      busy_q      <= busy_d;
    end
  end

  assign busy            = busy_q;
  assign fr.en_sync_out  = en_q;
  assign fr.cnt_sync_out = cnt_q;
  assign fr.dout0        = dout_q[0];
  assign fr.dout1        = dout_q[1];
  assign fr.dout2        = dout_q[2];
  assign fr.dout3        = dout_q[3];
  assign fr.frame_start  = fs_q;
  assign fr.sub_start    = ss_q;

endmodule

// File: tb/tb_adc_frame_sync_gen.sv
module tb_adc_frame_sync_gen;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic        adc_valid;
  logic [15:0] din0, din1, din2, din3;
  logic        busy;

  adc_frame_sync_gen_if #(.BITWIDTH(7)) fr ();

  adc_frame_sync_gen #(
    .BITWIDTH(7),
    .FFT_POINT(512),
    .SUB_FFT_POINT(128)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .stop(stop),
    .adc_valid(adc_valid),
    .din0(din0),
    .din1(din1),
    .din2(din2),
    .din3(din3),
    .busy(busy),
    .fr(fr.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        en;
    logic [8:0]  cnt;
    logic [63:0] d;
    logic        fs;
    logic        ss;
    logic        busy;
  } exp_t;

  exp_t        sb_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          bc       = 0;       // next expected beat index
  logic [8:0]  last_cnt = 9'd0;
  logic [63:0] last_d   = 64'd0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_pending();
    exp_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk("en_sync_out", 64'(fr.en_sync_out), 64'(e.en));
      chk("cnt_sync_out", 64'(fr.cnt_sync_out), 64'(e.cnt));
      chk("dout", {fr.dout3, fr.dout2, fr.dout1, fr.dout0}, e.d);
      chk("frame_start", 64'(fr.frame_start), 64'(e.fs));
      chk("sub_start", 64'(fr.sub_start), 64'(e.ss));
      chk("busy", 64'(busy), 64'(e.busy));
    end
  endtask

  // One clock of stimulus; expectation for the following cycle goes to the scoreboard
  task automatic step(input logic v, input logic st, input logic sp, input logic r,
                      input logic emit, input logic bsy);
    exp_t e;
    @(negedge clk);
    check_pending();
    rst       = r;
    adc_valid = v;
    start     = st;
    stop      = sp;
    din0      = 16'(bc);
    din1      = 16'($urandom);
    din2      = 16'($urandom);
    din3      = 16'($urandom);
    e = '0;
    if (r) begin
      bc       = 0;
      last_cnt = 9'd0;
      last_d   = 64'd0;
    end else if (emit) begin
      e.en     = 1'b1;
      e.fs     = (bc == 0);
      e.ss     = ((bc % 32) == 0);
      last_cnt = 9'(bc);
      last_d   = {din3, din2, din1, din0};
      bc       = (bc == 127) ? 0 : bc + 1;
    end
    e.cnt  = last_cnt;
    e.d    = last_d;
    e.busy = bsy;
    sb_q.push_back(e);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; adc_valid = 1'b0;
    din0 = 16'd0; din1 = 16'd0; din2 = 16'd0; din3 = 16'd0;

    // reset state
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // continuous valid: start in IDLE (beat ignored), then frames wrap 127 -> 0
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 130; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // stop at beat 40 -> drain through beat 127, stray start/stop ignored
    while (bc != 40) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 87; i++) step(1'b1, i == 5, i == 9, 1'b0, 1'b1, bc != 127);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // start and stop together in IDLE -> stays IDLE
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // gapped valid: one full frame at 50% duty, then stop on beat 127 -> IDLE directly
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 256; i++) step(i % 2 == 0, 1'b0, 1'b0, 1'b0, i % 2 == 0, 1'b1);
    for (int i = 0; i < 127; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // ARM waiting with no valid beats, then first beat is cnt 0
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // reset mid-frame at beat 60, then restart from cnt 0
    while (bc != 60) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // stop while in ARM: back to IDLE, nothing emitted
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    check_pending();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
